// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Framed serial byte stream to instruction-memory writer.
//                Frame = SYNC, LEN_HI, LEN_LO, 2*N data bytes (big-endian
//                words), CHK (mod-256 sum of data bytes). Holds the CPU
//                while loading and reports done / error / cause.
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
    parameter int         DEPTH          = 256,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        instr_mem_write_enable,
    output logic [15:0] MachineCodeAddress,
    output logic [15:0] MachineCodeData,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    localparam logic [1:0] c_ERR_LEN = 2'd1;
    localparam logic [1:0] c_ERR_CHK = 2'd2;
    localparam logic [1:0] c_ERR_TMO = 2'd3;

    // Counter only needs to reach TIMEOUT_CYCLES-1 before the timeout fires.
    localparam int                  c_TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]         c_DEPTH    = 17'(DEPTH);

    logic [3:0]         r_state;
    logic [3:0]         w_state_next;
    logic [15:0]        r_len;
    logic [15:0]        r_addr;
    logic [15:0]        r_data;
    logic [7:0]         r_chk;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;
    logic               r_hold;

    logic               w_accept;
    logic               w_is_sync;
    logic [15:0]        w_len_full;
    logic               w_len_bad;
    logic [15:0]        w_addr_inc;
    logic               w_tmo_state;
    logic               w_tmo_hit;
    logic               w_chk_ok;

    assign in_ready               = RSTn && (r_state != S_WRITE);
    assign instr_mem_write_enable = (r_state == S_WRITE);
    assign MachineCodeAddress     = r_addr;
    assign MachineCodeData        = r_data;
    assign cpu_hold               = r_hold;
    assign load_done              = r_done;
    assign load_error             = r_error;
    assign err_code               = r_err_code;

    assign w_accept    = in_valid && in_ready;
    assign w_is_sync   = (in_data == SYNC_BYTE);
    assign w_len_full  = {r_len[15:8], in_data};
    assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > c_DEPTH);
    assign w_addr_inc  = r_addr + 16'd1;
    assign w_chk_ok    = (in_data == r_chk);
    assign w_tmo_state = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                         (r_state == S_CHECK);
    assign w_tmo_hit   = w_tmo_state && !w_accept && (r_tmo == c_TMO_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a timeout overrides everything since no byte moved.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept && w_is_sync) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_state_next = w_len_bad ? S_ERROR : S_DATA_HI;
            end
            S_DATA_HI: begin
                if (w_accept) w_state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_accept) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_state_next = (w_addr_inc == r_len) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (w_accept) w_state_next = w_chk_ok ? S_DONE : S_ERROR;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_tmo_hit) w_state_next = S_ERROR;
    end

    // Datapath: length, word assembly, address, checksum, timeout and status.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_len      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_chk      <= '0;
            r_tmo      <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= '0;
            r_hold     <= 1'b0;
        end else begin
            if (w_tmo_state && !w_accept && !w_tmo_hit) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end

            if (w_tmo_hit) begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_TMO;
            end

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_accept && w_is_sync) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= '0;
                        r_hold     <= 1'b1;
                        r_addr     <= '0;
                        r_chk      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) r_len[15:8] <= in_data;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        if (w_len_bad) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_ERR_LEN;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_data[15:8] <= in_data;
                        r_chk        <= r_chk + in_data;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        r_data[7:0] <= in_data;
                        r_chk       <= r_chk + in_data;
                    end
                end
                S_WRITE: begin
                    r_addr <= w_addr_inc;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (w_chk_ok) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= c_ERR_CHK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader. Frame table with
//                expected end status, plus a write scoreboard fed as frames
//                are driven and drained by a strobe monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_loader;

    localparam int c_DEPTH = 256;
    localparam int c_TMO   = 20;

    logic        CLK;
    logic        RSTn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        instr_mem_write_enable;
    logic [15:0] MachineCodeAddress;
    logic [15:0] MachineCodeData;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;

    program_loader #(
        .DEPTH          (c_DEPTH),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .CLK                    (CLK),
        .RSTn                   (RSTn),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .instr_mem_write_enable (instr_mem_write_enable),
        .MachineCodeAddress     (MachineCodeAddress),
        .MachineCodeData        (MachineCodeData),
        .cpu_hold               (cpu_hold),
        .load_done              (load_done),
        .load_error             (load_error),
        .err_code               (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [95:0] bytes;      // first byte in [95:88]
        int          nbytes;
        int          skip;       // leading noise bytes before the sync
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic        exp_hold;
        logic [15:0] exp_addr;
        int          exp_writes;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;
    int   strobes  = 0;
    logic r_prev_we = 1'b0;
    wr_t  r_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe monitor: every write must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (RSTn && instr_mem_write_enable === 1'b1) begin
            strobes++;
            check("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("wr_single_cycle", {31'd0, r_prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         MachineCodeAddress, MachineCodeData);
            end else begin
                r_got = exp_q.pop_front();
                check("wr_addr", {16'd0, MachineCodeAddress}, {16'd0, r_got.addr});
                check("wr_data", {16'd0, MachineCodeData}, {16'd0, r_got.data});
            end
        end
        r_prev_we = instr_mem_write_enable;
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        int n  = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge CLK);
            ok = (in_ready === 1'b1);
            @(posedge CLK);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_stall: got in_ready low for %0d cycles expected accept", n);
        end
    endtask

    // Drives a frame with in_valid held high throughout; predicts the writes.
    task automatic send_frame(input vec_t v);
        logic [7:0] b;
        logic [7:0] prev = 8'h00;
        logic [7:0] hi   = 8'h00;
        int         n    = 0;
        bit         good = 1'b0;
        for (int i = 0; i < v.nbytes; i++) begin
            int j;
            b = v.bytes[95 - 8*i -: 8];
            j = i - v.skip;
            if (j == 1) hi = b;
            if (j == 2) begin
                n    = int'({hi, b});
                good = (n >= 1) && (n <= c_DEPTH);
            end
            if (good && j >= 3 && (j - 3) < 2*n && ((j - 3) % 2) == 1)
                exp_q.push_back({16'((j - 3) / 2), prev, b});
            prev = b;
            send_byte(b);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input vec_t v, input int strobes_before);
        check({tag, "_done"},  {31'd0, load_done},  {31'd0, v.exp_done});
        check({tag, "_error"}, {31'd0, load_error}, {31'd0, v.exp_err});
        check({tag, "_code"},  {30'd0, err_code},   {30'd0, v.exp_code});
        check({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, v.exp_hold});
        check({tag, "_addr"},  {16'd0, MachineCodeAddress}, {16'd0, v.exp_addr});
        check({tag, "_nwrites"}, 32'(strobes - strobes_before), 32'(v.exp_writes));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'd0, instr_mem_write_enable}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready},   32'd0);
        check({tag, "_addr"},  {16'd0, MachineCodeAddress}, 32'd0);
        check({tag, "_data"},  {16'd0, MachineCodeData},    32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
        check({tag, "_done"},  {31'd0, load_done},  32'd0);
        check({tag, "_error"}, {31'd0, load_error}, 32'd0);
        check({tag, "_code"},  {30'd0, err_code},   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;

        vecs[0] = '{96'hA5_00_02_12_34_AB_CD_BE_00_00_00_00,  8, 0, 1'b1, 1'b0, 2'd0, 1'b0, 16'd2, 2};
        vecs[1] = '{96'hA5_00_02_12_34_AB_CD_BF_00_00_00_00,  8, 0, 1'b0, 1'b1, 2'd2, 1'b1, 16'd2, 2};
        vecs[2] = '{96'hA5_01_01_00_00_00_00_00_00_00_00_00,  3, 0, 1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 0};
        vecs[3] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00,  3, 0, 1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 0};
        vecs[4] = '{96'h00_FF_5A_A5_00_02_12_34_AB_CD_BE_00, 11, 3, 1'b1, 1'b0, 2'd0, 1'b0, 16'd2, 2};
        vecs[5] = '{96'hA5_00_03_01_02_03_04_05_06_15_00_00, 10, 0, 1'b1, 1'b0, 2'd0, 1'b0, 16'd3, 3};
        vecs[6] = '{96'hA5_00_01_FF_02_01_00_00_00_00_00_00,  6, 0, 1'b1, 1'b0, 2'd0, 1'b0, 16'd1, 1};

        RSTn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < 7; v++) begin
            s0 = strobes;
            send_frame(vecs[v]);
            repeat (3) @(posedge CLK);
            #1;
            check_status($sformatf("vec%0d", v), vecs[v], s0);
        end

        // Timeout inside DATA_LO: error exactly after c_TMO idle cycles.
        s0 = strobes;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        in_valid = 1'b0;
        repeat (c_TMO - 1) @(posedge CLK);
        #1;
        check("tmo_not_yet", {31'd0, load_error}, 32'd0);
        @(posedge CLK);
        #1;
        check("tmo_error", {31'd0, load_error}, 32'd1);
        check("tmo_code",  {30'd0, err_code},   32'd3);
        check("tmo_hold",  {31'd0, cpu_hold},   32'd1);
        check("tmo_nwrites", 32'(strobes - s0), 32'd0);

        // Asynchronous reset while a write strobe is pending.
        s0 = strobes;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        in_valid = 1'b0;
        check("arst_strobe_pending", {31'd0, instr_mem_write_enable}, 32'd1);
        #1;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        check("arst_nwrites", 32'(strobes - s0), 32'd0);
        @(posedge CLK);
        #1;
        s0 = strobes;
        send_frame(vecs[0]);
        repeat (3) @(posedge CLK);
        #1;
        check_status("after_arst", vecs[0], s0);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
